// File: rtl/apb_master.sv
// ----------------------------------------------------------------------------
// apb_master
//   APB master FSM driving an internal APB slave (DEPTH x 32-bit register file).
//   Write requests are rising edges of in_valid, read requests are rising
//   edges of out_ready. A read targets the address of the most recent write.
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   rstn       in   1   synchronous reset, active HIGH (despite the name)
//   in_valid   in   1   write request strobe (edge triggered)
//   din_a      in  32   write address (word index)
//   din_b      in  32   write data
//   out_ready  in   1   read request strobe (edge triggered)
//   dout       out 32   registered read data
//   error      out  1   PSLVERR of the last completed transfer
// ----------------------------------------------------------------------------
module apb_master #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   input  logic [31:0] din_a,
   input  logic [31:0] din_b,
   input  logic        out_ready,
   output logic [31:0] dout,
   output logic        error
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   state_e      state_q, state_d;

   // request edge detection
   logic        wr_prev_q, rd_prev_q;
   logic        wr_arm_q, rd_arm_q;
   logic        wr_edge, rd_edge;

   // captured operands / pending requests
   logic [31:0] wa_q, wd_q, raddr_q;
   logic        wr_pend_q, rd_pend_q;
   logic        wr_req, rd_req;
   logic        launch_wr, launch_rd;

   // operand of the transfer in flight
   logic        op_write_q;
   logic [31:0] op_addr_q, op_data_q;

   // internal APB bus
   logic        psel, penable, pwrite, pready, pslverr, done;
   logic [31:0] paddr, pwdata, prdata;

   // slave storage
   logic [31:0] mem_q [DEPTH];
   logic [AW-1:0] midx;

   logic [31:0] dout_q;
   logic        error_q;

   // An input that was already high when reset released must be seen low
   // once (arm) before its next rise counts as a request.
   assign wr_edge = in_valid  & ~wr_prev_q & wr_arm_q;
   assign rd_edge = out_ready & ~rd_prev_q & rd_arm_q;
   assign wr_req  = wr_edge | wr_pend_q;
   assign rd_req  = rd_edge | rd_pend_q;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rstn) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // ------------------------------------------------------------------------
   // FSM: next state (write wins over read when both are requested)
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      launch_wr = 1'b0;
      launch_rd = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_req) begin
               state_d   = SETUP;
               launch_wr = 1'b1;
            end else if (rd_req) begin
               state_d   = SETUP;
               launch_rd = 1'b1;
            end
         end
         SETUP:   state_d = ACCESS;
         ACCESS:  if (pready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs onto the internal APB bus
   // ------------------------------------------------------------------------
   always_comb begin
      psel    = (state_q != IDLE);
      penable = (state_q == ACCESS);
      pwrite  = op_write_q & psel;
      paddr   = op_addr_q;
      pwdata  = op_data_q;
      done    = penable & pready;
   end

   // ------------------------------------------------------------------------
   // Master datapath: edge history, capture, pending flags, results
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rstn) begin
         wr_prev_q  <= 1'b0;
         rd_prev_q  <= 1'b0;
         wr_arm_q   <= 1'b0;
         rd_arm_q   <= 1'b0;
         wa_q       <= '0;
         wd_q       <= '0;
         raddr_q    <= '0;
         wr_pend_q  <= 1'b0;
         rd_pend_q  <= 1'b0;
         op_write_q <= 1'b0;
         op_addr_q  <= '0;
         op_data_q  <= '0;
         dout_q     <= '0;
         error_q    <= 1'b0;
      end else begin
         wr_prev_q <= in_valid;
         rd_prev_q <= out_ready;
         wr_arm_q  <= wr_arm_q | ~in_valid;
         rd_arm_q  <= rd_arm_q | ~out_ready;

         // Every write edge captures its operands and becomes the read target,
         // whether or not the FSM can start it right away.
         if (wr_edge) begin
            wa_q    <= din_a;
            wd_q    <= din_b;
            raddr_q <= din_a;
         end

         // A launch consumes the request; otherwise an edge sets (or merges
         // into) the pending flag.
         wr_pend_q <= launch_wr ? 1'b0 : (wr_pend_q | wr_edge);
         rd_pend_q <= launch_rd ? 1'b0 : (rd_pend_q | rd_edge);

         if (launch_wr) begin
            // On a fresh edge the capture registers are not loaded yet.
            op_write_q <= 1'b1;
            op_addr_q  <= wr_edge ? din_a : wa_q;
            op_data_q  <= wr_edge ? din_b : wd_q;
         end else if (launch_rd) begin
            op_write_q <= 1'b0;
            op_addr_q  <= raddr_q;
            op_data_q  <= '0;
         end

         if (done) begin
            error_q <= pslverr;
            if (!op_write_q && !pslverr) dout_q <= prdata;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Internal APB slave: zero wait state, error on out-of-range address
   // ------------------------------------------------------------------------
   assign pready  = 1'b1;
   assign pslverr = psel & (paddr >= DEPTH_W);
   assign midx    = paddr[AW-1:0];
   assign prdata  = (psel && !pwrite && !pslverr) ? mem_q[midx] : '0;

   always_ff @(posedge clk) begin
      if (rstn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (psel && penable && pready && pwrite && !pslverr) begin
         mem_q[midx] <= pwdata;
      end
   end

   assign dout  = dout_q;
   assign error = error_q;

endmodule

// File: tb/tb_apb_master.sv
// ----------------------------------------------------------------------------
// tb_apb_master
//   Self-checking bench for apb_master. A transaction-level model keeps the
//   register file, last write address, dout and error; directed scenarios are
//   followed by a randomized mix of writes, reads and simultaneous pairs.
// ----------------------------------------------------------------------------
module tb_apb_master;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] din_a, din_b;
   logic [31:0] dout;
   logic        error;

   always #2 clk = ~clk;

   apb_master #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .din_a     (din_a),
      .din_b     (din_b),
      .out_ready (out_ready),
      .dout      (dout),
      .error     (error)
   );

   int n_chk = 0;
   int n_err = 0;

   // number of SETUP phases seen on the internal bus
   int setup_cnt = 0;
   always @(posedge clk) if (dut.psel && !dut.penable) setup_cnt <= setup_cnt + 1;

   // transaction-level reference
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_dout, m_raddr;
   logic        m_err;

   function automatic void m_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_dout = '0; m_raddr = '0; m_err = 1'b0;
   endfunction

   function automatic void m_write(logic [31:0] a, logic [31:0] d);
      m_raddr = a;
      m_err   = (a >= DEPTH);
      if (!m_err) m_mem[a] = d;
   endfunction

   function automatic void m_read();
      m_err = (m_raddr >= DEPTH);
      if (!m_err) m_dout = m_mem[m_raddr];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      cyc(2);
      rstn = 1'b0;
      m_reset();
   endtask

   // One request (write, read or both) held `hold` cycles, then enough idle
   // cycles for a write+read pair to drain. Operand inputs are scrambled after
   // the pulse so late sampling would be noticed.
   task automatic op(bit wr, bit rd, logic [31:0] a, logic [31:0] d, int hold);
      @(negedge clk);
      in_valid = wr; out_ready = rd; din_a = a; din_b = d;
      cyc(hold);
      in_valid = 1'b0; out_ready = 1'b0; din_a = $urandom; din_b = $urandom;
      cyc(8 - hold);
      if (wr) m_write(a, d);
      if (rd) m_read();
   endtask

   task automatic chk_state(string tag);
      chk({tag, "_dout"}, dout, m_dout);
      chk({tag, "_err"}, {31'b0, error}, {31'b0, m_err});
   endtask

   task automatic chk_mem(string tag);
      for (int i = 0; i < DEPTH; i++) chk(tag, dut.mem_q[i], m_mem[i]);
   endtask

   initial begin
      int c0;
      logic [31:0] a, d;
      int kind;

      rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din_a = '0; din_b = '0;
      m_reset();
      do_reset();
      chk_state("reset");

      // single write then read with latency check on the read
      op(1, 0, 32'd1, 32'd2, 2);
      chk_state("w1");
      @(negedge clk); out_ready = 1'b1;
      cyc(1); chk("lat_k",  dout, 32'd0);
      cyc(1); chk("lat_k1", dout, 32'd0);
      cyc(1); chk("lat_k2", dout, 32'd2);
      out_ready = 1'b0; cyc(3); m_read();
      chk_state("r1");

      // write/read pairs
      for (int i = 2; i <= 5; i++) begin
         op(1, 0, i, i + 1, 1);
         op(0, 1, 32'd0, 32'd0, 1);
         chk_state("pair");
      end

      // out-of-range write then read
      op(1, 0, 32'd16, 32'h0000_DEAD, 1);
      chk_state("oor_w");
      op(0, 1, 32'd0, 32'd0, 1);
      chk_state("oor_r");
      chk_mem("oor_mem");

      // simultaneous write and read edges
      c0 = setup_cnt;
      op(1, 1, 32'd7, 32'hA5A5_A5A5, 1);
      chk_state("simul");
      chk("simul_setups", setup_cnt - c0, 32'd2);

      // level held 20 clocks -> one transfer
      c0 = setup_cnt;
      op(1, 0, 32'd9, 32'h1357_9BDF, 1);
      @(negedge clk); in_valid = 1'b1; din_a = 32'd5; din_b = 32'hCAFE_0005;
      cyc(20); in_valid = 1'b0; cyc(4);
      m_write(32'd5, 32'hCAFE_0005);
      chk("hold_setups", setup_cnt - c0, 32'd2);
      op(0, 1, 32'd0, 32'd0, 1);
      chk_state("hold_r");

      // reset during SETUP of a write to address 2
      @(negedge clk); in_valid = 1'b1; din_a = 32'd2; din_b = 32'h2222_2222;
      cyc(1);
      rstn = 1'b1; in_valid = 1'b0;
      cyc(2); rstn = 1'b0; m_reset();
      cyc(4);
      chk_state("abort");
      chk("abort_mem2", dut.mem_q[2], 32'd0);

      // input held high through reset release is not a request
      @(negedge clk); rstn = 1'b1; in_valid = 1'b1; din_a = 32'd3; din_b = 32'h1234;
      cyc(2); rstn = 1'b0; m_reset();
      c0 = setup_cnt;
      cyc(5); in_valid = 1'b0; cyc(3);
      chk("held_setups", setup_cnt - c0, 32'd0);
      chk("held_mem3", dut.mem_q[3], 32'd0);
      op(1, 0, 32'd3, 32'h55, 1);
      op(0, 1, 32'd0, 32'd0, 1);
      chk_state("rearm");

      // randomized mix
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0)      a = $urandom | 32'h8000_0000;
         else if (kind < 3)  a = DEPTH + $urandom_range(0, 3);
         else                a = $urandom_range(0, DEPTH - 1);
         d = $urandom;
         kind = $urandom_range(0, 3);
         op(kind != 2, kind >= 2, a, d, $urandom_range(1, 3));
         chk_state("rnd");
      end
      chk_mem("final_mem");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
